// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: req/ack data-memory transaction, lane steering, load
// extension, alignment check and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RegWriteM,
  input  logic                      MemReadM,
  input  logic                      MemWriteM,
  input  logic [1:0]                Mem_to_RegM,
  input  logic [2:0]                funct3M,
  input  logic [4:0]                RDM,
  input  logic [31:0]               ALUOutM,
  input  logic [31:0]               WriteDataM,
  input  logic [31:0]               PCPlus4M,
  mem_access_stage_if.master        dmem,
  output logic                      StallM,
  output logic                      MisalignM,
  output logic                      BusErrM,
  output logic                      RegWriteW,
  output logic [1:0]                Mem_to_RegW,
  output logic [4:0]                RDW,
  output logic [31:0]               ALUOutW,
  output logic [31:0]               ReadDataW,
  output logic [31:0]               PCPlus4W
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q;
  logic             err_q;
  logic [31:0]      rdata_q;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        aligned_acc;
  logic        timeout_hit;
  logic [1:0]  k;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_fmt;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;

  assign k           = ALUOutM[1:0];
  assign access      = MemReadM | MemWriteM;
  assign is_byte     = (funct3M[1:0] == 2'b00);
  assign is_half     = (funct3M[1:0] == 2'b01);
  assign is_word     = ~is_byte & ~is_half;
  assign misaligned  = (is_half & k[0]) | (is_word & (k != 2'b00));
  assign aligned_acc = access & ~misaligned;
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Pick the addressed lane from the returned word and extend it.
  always_comb begin
    ld_byte  = 8'h00;
    ld_half  = 16'h0000;
    load_fmt = 32'h0000_0000;
    case (k)
      2'd0:    ld_byte = dmem.dmem_rdata[7:0];
      2'd1:    ld_byte = dmem.dmem_rdata[15:8];
      2'd2:    ld_byte = dmem.dmem_rdata[23:16];
      default: ld_byte = dmem.dmem_rdata[31:24];
    endcase
    ld_half = k[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
    if (is_byte)
      load_fmt = {{24{~funct3M[2] & ld_byte[7]}}, ld_byte};
    else if (is_half)
      load_fmt = {{16{~funct3M[2] & ld_half[15]}}, ld_half};
    else
      load_fmt = dmem.dmem_rdata;
  end

  // Replicate store data across lanes; strobes select the addressed bytes.
  always_comb begin
    st_wdata = WriteDataM;
    st_wstrb = 4'b0000;
    if (is_byte)
      st_wdata = {4{WriteDataM[7:0]}};
    else if (is_half)
      st_wdata = {2{WriteDataM[15:0]}};
    if (MemWriteM) begin
      if (is_byte)
        st_wstrb = 4'b0001 << k;
      else if (is_half)
        st_wstrb = 4'b0011 << k;
      else
        st_wstrb = 4'b1111;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = MemWriteM;
  assign dmem.dmem_addr  = {ALUOutM[31:2], 2'b00};
  assign dmem.dmem_wdata = st_wdata;
  assign dmem.dmem_wstrb = st_wstrb;

  // Stall covers the detect cycle in IDLE and every REQ cycle.
  assign StallM    = ((state_q == IDLE) & aligned_acc) | (state_q == REQ);
  assign MisalignM = (state_q == IDLE) & access & misaligned;
  assign BusErrM   = (state_q == REQ) & ~dmem.dmem_ack & timeout_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      RegWriteW   <= 1'b0;
      Mem_to_RegW <= '0;
      RDW         <= '0;
      ALUOutW     <= '0;
      ReadDataW   <= '0;
      PCPlus4W    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (aligned_acc) begin
            state_q   <= REQ;
            req_q     <= 1'b1;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            RegWriteW <= 1'b0;
          end else begin
            RegWriteW   <= RegWriteM & ~access;
            Mem_to_RegW <= Mem_to_RegM;
            RDW         <= RDM;
            ALUOutW     <= ALUOutM;
            ReadDataW   <= '0;
            PCPlus4W    <= PCPlus4M;
          end
        end
        REQ: begin
          RegWriteW <= 1'b0;
          if (dmem.dmem_ack) begin
            rdata_q <= load_fmt;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          RegWriteW   <= RegWriteM & ~err_q;
          Mem_to_RegW <= Mem_to_RegM;
          RDW         <= RDM;
          ALUOutW     <= ALUOutM;
          ReadDataW   <= rdata_q;
          PCPlus4W    <= PCPlus4M;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a memory responder on the bus side
// and expected MEM/WB results queued per issued instruction.
module tb_mem_access_stage;

  localparam int unsigned TIMEOUT = 16;

  typedef struct {
    logic        rw;
    logic [1:0]  m2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] pc4;
  } wb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        MemReadM;
  logic        MemWriteM;
  logic [1:0]  Mem_to_RegM;
  logic [2:0]  funct3M;
  logic [4:0]  RDM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        RegWriteW;
  logic [1:0]  Mem_to_RegW;
  logic [4:0]  RDW;
  logic [31:0] ALUOutW;
  logic [31:0] ReadDataW;
  logic [31:0] PCPlus4W;

  int checks = 0;
  int errors = 0;
  int seq    = 0;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  bus_t cur_b;

  logic        resp_ack = 1'b0;
  logic        man_ack  = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  bit          ack_en    = 1'b1;
  int          ack_delay = 0;
  int          req_cycles = 0;

  mem_access_stage_if dut_if ();

  assign dut_if.dmem_ack   = resp_ack | man_ack;
  assign dut_if.dmem_rdata = mem_rdata;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemReadM    (MemReadM),
    .MemWriteM   (MemWriteM),
    .Mem_to_RegM (Mem_to_RegM),
    .funct3M     (funct3M),
    .RDM         (RDM),
    .ALUOutM     (ALUOutM),
    .WriteDataM  (WriteDataM),
    .PCPlus4M    (PCPlus4M),
    .dmem        (dut_if.master),
    .StallM      (StallM),
    .MisalignM   (MisalignM),
    .BusErrM     (BusErrM),
    .RegWriteW   (RegWriteW),
    .Mem_to_RegW (Mem_to_RegW),
    .RDW         (RDW),
    .ALUOutW     (ALUOutW),
    .ReadDataW   (ReadDataW),
    .PCPlus4W    (PCPlus4W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory responder: checks the request against the queued bus expectation
  // and acks after ack_delay REQ cycles.
  always @(negedge clk) begin
    resp_ack = 1'b0;
    if (dut_if.dmem_req) begin
      if (req_cycles == 0) begin
        if (bus_q.size() == 0) begin
          chk("spurious req", 32'(dut_if.dmem_req), 32'd0);
        end else begin
          cur_b = bus_q.pop_front();
          chk("bus addr", dut_if.dmem_addr, cur_b.addr);
          chk("bus we", 32'(dut_if.dmem_we), 32'(cur_b.we));
          chk("bus wstrb", 32'(dut_if.dmem_wstrb), 32'(cur_b.wstrb));
          if (cur_b.we) chk("bus wdata", dut_if.dmem_wdata, cur_b.wdata);
        end
      end else begin
        chk("bus addr stable", dut_if.dmem_addr, cur_b.addr);
        chk("bus wstrb stable", 32'(dut_if.dmem_wstrb), 32'(cur_b.wstrb));
      end
      if (ack_en && req_cycles == ack_delay) resp_ack = 1'b1;
      req_cycles++;
    end else begin
      req_cycles = 0;
    end
  end

  task automatic drive_nop();
    RegWriteM   = 1'b0;
    MemReadM    = 1'b0;
    MemWriteM   = 1'b0;
    Mem_to_RegM = 2'b00;
    funct3M     = 3'b000;
    RDM         = 5'd0;
    ALUOutM     = 32'h0;
    WriteDataM  = 32'h0;
    PCPlus4M    = 32'h0;
  endtask

  // Called #1 after a clock edge; returns #1 after the edge that retires the op.
  task automatic issue(input string tag, input logic rd_en, input logic wr_en, input logic rw,
                       input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] word, input int delay, input logic mis,
                       input logic [31:0] exp_rdata, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wdata);
    wb_t  w;
    wb_t  e;
    bus_t b;
    int   stalls;
    int   mis_n;
    int   err_n;
    int   exp_stall;
    bit   done;
    logic acc;
    logic tmo;
    acc = rd_en | wr_en;
    tmo = (delay < 0);
    seq++;
    RegWriteM   = rw;
    MemReadM    = rd_en;
    MemWriteM   = wr_en;
    Mem_to_RegM = rd_en ? 2'b01 : 2'b00;
    funct3M     = f3;
    RDM         = 5'(seq);
    ALUOutM     = addr;
    WriteDataM  = wdata;
    PCPlus4M    = 32'h0000_1000 + 32'(seq * 4);
    mem_rdata   = word;
    ack_delay   = delay;
    ack_en      = !tmo;
    if (acc && !mis) begin
      b.we    = wr_en;
      b.addr  = {addr[31:2], 2'b00};
      b.wstrb = exp_strb;
      b.wdata = exp_wdata;
      bus_q.push_back(b);
    end
    w.rw    = rw & ~mis & ~(acc & tmo);
    w.m2r   = Mem_to_RegM;
    w.rd    = RDM;
    w.alu   = addr;
    w.pc4   = PCPlus4M;
    w.rdata = (acc && !mis && !tmo) ? exp_rdata : 32'h0;
    wb_q.push_back(w);
    if (!acc || mis) exp_stall = 0;
    else if (tmo)    exp_stall = 1 + int'(TIMEOUT);
    else             exp_stall = 2 + delay;

    stalls = 0; mis_n = 0; err_n = 0; done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (MisalignM) mis_n++;
      if (BusErrM)   err_n++;
      if (StallM) stalls++;
      else        done = 1'b1;
    end
    chk({tag, " retire"}, 32'(done), 32'd1);
    @(posedge clk);
    #1;
    e = wb_q.pop_front();
    chk({tag, " RegWriteW"}, 32'(RegWriteW), 32'(e.rw));
    chk({tag, " Mem_to_RegW"}, 32'(Mem_to_RegW), 32'(e.m2r));
    chk({tag, " RDW"}, 32'(RDW), 32'(e.rd));
    chk({tag, " ALUOutW"}, ALUOutW, e.alu);
    chk({tag, " ReadDataW"}, ReadDataW, e.rdata);
    chk({tag, " PCPlus4W"}, PCPlus4W, e.pc4);
    chk({tag, " stall cycles"}, 32'(stalls), 32'(exp_stall));
    chk({tag, " misalign pulses"}, 32'(mis_n), 32'(mis ? 1 : 0));
    chk({tag, " buserr pulses"}, 32'(err_n), 32'((acc && !mis && tmo) ? 1 : 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b0;
    drive_nop();
    #12;
    chk("reset dmem_req", 32'(dut_if.dmem_req), 32'd0);
    chk("reset StallM", 32'(StallM), 32'd0);
    chk("reset MisalignM", 32'(MisalignM), 32'd0);
    chk("reset BusErrM", 32'(BusErrM), 32'd0);
    chk("reset RegWriteW", 32'(RegWriteW), 32'd0);
    chk("reset ALUOutW", ALUOutW, 32'd0);
    chk("reset PCPlus4W", PCPlus4W, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    //        tag          rd wr rw f3      addr          wdata         word          dly mis exp_rdata     strb     exp_wdata
    issue("alu op",        0, 0, 1, 3'b000, 32'h0000_0055, 32'h0,        32'h0,         0, 0, 32'h0,        4'b0000, 32'h0);
    issue("lw 0x100",      1, 0, 1, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF,  0, 0, 32'hDEADBEEF, 4'b0000, 32'h0);
    issue("lb 0x103",      1, 0, 1, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 2, 0, 32'hFFFF_FF80, 4'b0000, 32'h0);
    issue("lbu 0x103",     1, 0, 1, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1, 0, 32'h0000_0080, 4'b0000, 32'h0);
    issue("lh 0x102",      1, 0, 1, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, 0, 32'hFFFF_80FF, 4'b0000, 32'h0);
    issue("lhu 0x102",     1, 0, 1, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_1234, 3, 0, 32'h0000_80FF, 4'b0000, 32'h0);
    issue("lb 0x100",      1, 0, 1, 3'b000, 32'h0000_0100, 32'h0,        32'h80FF_1234, 0, 0, 32'h0000_0034, 4'b0000, 32'h0);
    issue("lh 0x100",      1, 0, 1, 3'b001, 32'h0000_0100, 32'h0,        32'h80FF_9234, 0, 0, 32'hFFFF_9234, 4'b0000, 32'h0);
    issue("sb 0x202",      0, 1, 0, 3'b000, 32'h0000_0202, 32'h0000_00A5, 32'h0,        0, 0, 32'h0,        4'b0100, 32'hA5A5_A5A5);
    issue("sh 0x202",      0, 1, 0, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0,        1, 0, 32'h0,        4'b1100, 32'h1234_1234);
    issue("sw 0x204",      0, 1, 0, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        0, 0, 32'h0,        4'b1111, 32'hCAFE_F00D);
    issue("rd+wr is sb",   1, 1, 0, 3'b000, 32'h0000_0301, 32'h0000_003C, 32'h0,        0, 0, 32'h0,        4'b0010, 32'h3C3C_3C3C);
    issue("lw 0x101 mis",  1, 0, 1, 3'b010, 32'h0000_0101, 32'h0,        32'h1111_1111, 0, 1, 32'h0,        4'b0000, 32'h0);
    issue("lh 0x103 mis",  1, 0, 1, 3'b001, 32'h0000_0103, 32'h0,        32'h1111_1111, 0, 1, 32'h0,        4'b0000, 32'h0);
    issue("sh 0x201 mis",  0, 1, 0, 3'b001, 32'h0000_0201, 32'h0000_BEEF, 32'h0,        0, 1, 32'h0,        4'b0000, 32'h0);
    issue("sw 0x206 mis",  0, 1, 0, 3'b010, 32'h0000_0206, 32'h0000_BEEF, 32'h0,        0, 1, 32'h0,        4'b0000, 32'h0);
    issue("lw timeout",    1, 0, 1, 3'b010, 32'h0000_0140, 32'h0,        32'h1234_5678, -1, 0, 32'h0,       4'b0000, 32'h0);
    issue("alu after err", 0, 0, 1, 3'b000, 32'h0000_0077, 32'h0,        32'h0,         0, 0, 32'h0,        4'b0000, 32'h0);

    // Reset asserted while a load sits in REQ waiting for its ack.
    RegWriteM = 1'b1; MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010;
    ALUOutM = 32'h0000_0300; RDM = 5'd9; ack_en = 1'b0;
    cur_b.we = 1'b0; cur_b.addr = 32'h0000_0300; cur_b.wstrb = 4'b0000; cur_b.wdata = 32'h0;
    bus_q.push_back(cur_b);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = dut_if.dmem_req;
    end
    chk("rst-mid req seen", 32'(seen), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst-mid dmem_req", 32'(dut_if.dmem_req), 32'd0);
    chk("rst-mid RegWriteW", 32'(RegWriteW), 32'd0);
    chk("rst-mid ALUOutW", ALUOutW, 32'd0);
    drive_nop();
    #1;
    chk("rst-mid StallM", 32'(StallM), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    // Late ack while idle must not start or complete anything.
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("late ack StallM", 32'(StallM), 32'd0);
    chk("late ack dmem_req", 32'(dut_if.dmem_req), 32'd0);
    @(posedge clk);
    #1;
    issue("alu after rst", 0, 0, 1, 3'b000, 32'h0000_0099, 32'h0,        32'h0,         0, 0, 32'h0,        4'b0000, 32'h0);
    issue("lw 0x180",      1, 0, 1, 3'b010, 32'h0000_0180, 32'h0,        32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D, 4'b0000, 32'h0);

    // Stray ack right after a completed load, then a normal load.
    drive_nop();
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    chk("stray ack dmem_req", 32'(dut_if.dmem_req), 32'd0);
    @(posedge clk);
    #1;
    issue("lw after stray", 1, 0, 1, 3'b010, 32'h0000_0184, 32'h0,       32'h5555_AAAA, 1, 0, 32'h5555_AAAA, 4'b0000, 32'h0);

    drive_nop();
    repeat (2) @(posedge clk);
    #1;
    chk("wb queue drained", 32'(wb_q.size()), 32'd0);
    chk("bus queue drained", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 5-stage RV32I pipeline. Receives the EX/MEM register outputs (control, ALU result, store data, destination register) from the execute stage.
- Runs loads and stores as a request/acknowledge transaction on the data-memory bus, stalling the pipeline while a transaction is in flight.
- Performs byte/halfword lane steering, load sign/zero extension and alignment checking.
- Registers the MEM/WB pipeline outputs.

Parameters:
- TIMEOUT, 16: max cycles in REQ waiting for dmem_ack before a bus error is flagged.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- RegWriteM  in  1  register-write enable from EX/MEM
- MemReadM  in  1  load request
- MemWriteM  in  1  store request
- Mem_to_RegM  in  2  writeback select, passed through
- funct3M  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- RDM  in  5  destination register
- ALUOutM  in  32  effective address / ALU result
- WriteDataM  in  32  store data, forwarded
- PCPlus4M  in  32  return address, passed through
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  {ALUOutM[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes; 0000 for loads
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  32  load word, valid with ack
- StallM  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- MisalignM  out  1  one-cycle misaligned-access flag
- BusErrM  out  1  one-cycle timeout flag
- RegWriteW, Mem_to_RegW[2], RDW[5], ALUOutW[32], ReadDataW[32], PCPlus4W[32]  out  MEM/WB register

Behaviour:
- Reset (async, rst=0): FSM to IDLE, counter 0. dmem_req=0, StallM=0, MisalignM=0, BusErrM=0. All W registers 0.
- Access = MemReadM|MemWriteM. If both are set, the access is a store.
- Misaligned conditions:
  - h/hu/sh with ALUOutM[0]=1
  - w/sw with ALUOutM[1:0]!=00
- A misaligned access issues no bus transaction and raises no stall. In that cycle MisalignM=1 combinationally. At the next edge W registers load with RegWriteW forced 0.
- FSM states:
  - IDLE:
    - No access: W regs load from M inputs every edge, ReadDataW=0.
    - Aligned access: StallM=1; next state REQ; counter cleared.
  - REQ: dmem_req=1, StallM=1.
    - dmem_ack=1: capture formatted load data into internal register; next DONE.
    - No ack: counter++. At counter==TIMEOUT-1 without ack, BusErrM=1 for this cycle, captured data=0; next DONE.
  - DONE: StallM=0, dmem_req=0. At the edge, W regs load from M inputs plus captured data. RegWriteW is forced 0 if a bus error occurred. Next IDLE.
- While StallM=1, W regs load a bubble: RegWriteW=0, others unchanged. M inputs must stay stable, since upstream is frozen.
- Latency, ack in first REQ cycle: stall for 2 cycles (IDLE-detect, REQ); W regs loaded at the end of DONE. Each ack wait cycle adds 1.
- dmem_addr, dmem_we, dmem_wdata and dmem_wstrb are combinational from M inputs and stable throughout REQ.
- Store formatting (k = ALUOutM[1:0]):
  - sb: wstrb=0001<<k, wdata = byte replicated ×4
  - sh: wstrb=0011<<k, wdata = half replicated ×2
  - sw: wstrb=1111
- Load formatting: select the byte/half at k from dmem_rdata. Sign-extend for 000/001, zero-extend for 100/101; 010 passes the word.
- dmem_ack outside REQ is ignored.
- Reset mid-transaction: immediate return to IDLE, dmem_req drops, no W update. A later ack is ignored.

Test Plan:
- lw, ALUOutM=0x100, ack 1st REQ cycle, rdata=0xDEADBEEF:
  - StallM high for 2 cycles.
  - Next cycle RegWriteW=1, ReadDataW=0xDEADBEEF, dmem_addr=0x100, wstrb=0000.
- lb addr 0x103, rdata=0x80FF_1234:
  - ReadDataW=0xFFFFFF80.
  - Same with lbu → 0x00000080.
  - lh addr 0x102 → 0xFFFF80FF.
- sb addr 0x202, WriteDataM=0x000000A5:
  - wstrb=0100, wdata=0xA5A5A5A5, dmem_we=1.
  - sh addr 0x202, data 0x1234 → wstrb=1100, wdata=0x12341234.
- lw addr 0x101: MisalignM=1 one cycle, dmem_req never asserted, StallM=0, RegWriteW=0.
- lw, ack withheld: after TIMEOUT cycles in REQ, BusErrM pulses, ReadDataW=0, RegWriteW=0, pipeline resumes.
- Corner cases:
  - rst low during REQ: dmem_req=0 immediately, FSM back to IDLE.
  - Late ack ignored.
  - Non-memory ALU op (RegWriteM=1, ALUOutM=0x55) reaches W next cycle, zero stall.
